mux2to1: RTL and testbench
==========================

MUX2TO1 -- requirements
Module: mux2to1

Interface
REQ-001 Parameter N, default 32: data width in bits, legal range 1..1024.
REQ-002 Parameter CNT_W, default 16: width of the select-switch counter, legal range 1..32.
REQ-003 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port A, input, N: data input selected when S=0.
REQ-006 Port B, input, N: data input selected when S=1.
REQ-007 Port S, input, 1: select line.
REQ-008 Port Y, output, N: combinational mux output.
REQ-009 Port Y_q, output, N: registered copy of Y.
REQ-010 Port switch_cnt, output, CNT_W: number of S transitions seen since reset.

Function
REQ-011 Y SHALL equal A when S=0 and B when S=1, with zero latency (purely combinational, no clock dependence).
REQ-012 When S is X or Z, Y SHALL be all-X in simulation; synthesis behaviour for this case is don't-care.
REQ-013 Y_q SHALL load Y on every rising clk edge when rst=0, giving 1-cycle latency relative to Y.
REQ-014 An internal register sel_q SHALL capture S on every rising clk edge.
REQ-015 switch_cnt SHALL increment by 1 on each rising edge at which S differs from sel_q.
REQ-016 switch_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-017 The first cycle after reset release SHALL NOT count as a switch; sel_q is loaded from S during reset.
REQ-018 A, B and S changing in the same cycle SHALL be handled the same as any single change: Y follows immediately, and Y_q follows at the next edge.

Reset
REQ-019 While rst=1 at a rising edge: Y_q SHALL become 0, switch_cnt SHALL become 0, and sel_q SHALL become S.
REQ-020 Y SHALL NOT be affected by rst.
REQ-021 Asserting rst mid-operation SHALL clear Y_q and switch_cnt at the next edge; no other state is retained.

Configuration
REQ-022 Macro MUX2TO1_STATS_EN defined: switch_cnt and sel_q SHALL be implemented as specified above.
REQ-023 Macro MUX2TO1_STATS_EN undefined: switch_cnt SHALL be tied to constant 0, sel_q and the counter SHALL be removed, and Y and Y_q SHALL be unchanged.

Structure
REQ-024 Package mux2to1_pkg SHALL hold DEFAULT_N=32, DEFAULT_CNT_W=16 and the saturation-max function for CNT_W.
REQ-025 The combinational selection SHALL live in sub-module mux2to1_core (parameter N; ports A, B, S, Y).
REQ-026 mux2to1 SHALL wrap mux2to1_core and add the Y_q register and the optional statistics logic.
REQ-027 mux2to1 SHALL be instantiable with implicit .* port connection to a bench declaring clk, rst, A, B, S and Y_q/switch_cnt as needed.

Verification
REQ-028 A=AAAA_AAAA, B=5555_5555, S=0, wait 10 time units -> Y=AAAA_AAAA.
REQ-029 Same A and B, S=1 -> Y=5555_5555 with no clock edge required; Y_q=5555_5555 one edge later.
REQ-030 A=1234_5678, B=8765_4321, S toggled 0 then 1 -> Y=1234_5678, then 8765_4321.
REQ-031 Reset held for 2 cycles, then S toggled 5 times over 10 cycles -> switch_cnt=5 and Y_q=0 during reset; with CNT_W=2, switch_cnt saturates at 3.
REQ-032 rst asserted mid-run with switch_cnt=4 -> switch_cnt=0 and Y_q=0 at the next edge while Y still tracks S.
REQ-033 Build without MUX2TO1_STATS_EN, toggle S 5 times -> switch_cnt=0, and Y/Y_q results identical to REQ-028..REQ-030.

Source files
------------

// File: rtl/mux2to1_pkg.sv
// Shared defaults and helpers for the mux2to1 block.
package mux2to1_pkg;

  localparam int unsigned DEFAULT_N     = 32;
  localparam int unsigned DEFAULT_CNT_W = 16;

  // Largest value representable in a w-bit counter, for w in 1..32.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/mux2to1_if.sv
// Signal bundle for a mux2to1 instance: driver side is master, mux side is slave.
interface mux2to1_if
  import mux2to1_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input logic clk
);

  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic             S;
  logic [N-1:0]     Y;
  logic [N-1:0]     Y_q;
  logic [CNT_W-1:0] switch_cnt;

  modport master (input clk, output A, output B, output S,
                  input Y, input Y_q, input switch_cnt);
  modport slave  (input clk, input A, input B, input S,
                  output Y, output Y_q, output switch_cnt);

endinterface

// File: rtl/mux2to1_core.sv
// Purely combinational 2:1 selector; an unknown select propagates as all-X.
module mux2to1_core #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         S,
  output logic [N-1:0] Y
);

  always_comb begin
    Y = 'x;
    case (S)
      1'b0:    Y = A;
      1'b1:    Y = B;
      default: Y = 'x;
    endcase
  end

endmodule

// File: rtl/mux2to1.sv
// 2:1 mux with registered output and optional select-switch counter.
// Define MUX2TO1_STATS_EN to build sel_q and the saturating switch_cnt.
module mux2to1
  import mux2to1_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic             S,
  output logic [N-1:0]     Y,
  output logic [N-1:0]     Y_q,
  output logic [CNT_W-1:0] switch_cnt
);

  mux2to1_core #(.N(N)) u_core (
    .A (A),
    .B (B),
    .S (S),
    .Y (Y)
  );

  always_ff @(posedge clk) begin
    if (rst) Y_q <= '0;
    else     Y_q <= Y;
  end

`ifdef MUX2TO1_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             sel_q;
  logic [CNT_W-1:0] cnt;

  // sel_q tracks S even in reset so the first post-reset edge never counts.
  always_ff @(posedge clk) begin
    sel_q <= S;
    if (rst) begin
      cnt <= '0;
    end else if ((S != sel_q) && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign switch_cnt = cnt;
`else
  assign switch_cnt = '0;
`endif

endmodule

// File: tb/tb_mux2to1.sv
// Directed self-checking bench for mux2to1 (default width and a CNT_W=2 copy).
module tb_mux2to1;

`ifdef MUX2TO1_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux2to1_if #(.N(32), .CNT_W(16)) bus (.clk(clk));

  logic [31:0] y_sat;
  logic [31:0] yq_sat;
  logic [1:0]  cnt_sat;

  int checks = 0;
  int errors = 0;

  mux2to1 #(.N(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (bus.A),
    .B          (bus.B),
    .S          (bus.S),
    .Y          (bus.Y),
    .Y_q        (bus.Y_q),
    .switch_cnt (bus.switch_cnt)
  );

  mux2to1 #(.N(32), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .A          (bus.A),
    .B          (bus.B),
    .S          (bus.S),
    .Y          (y_sat),
    .Y_q        (yq_sat),
    .switch_cnt (cnt_sat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input logic [63:0] v);
    return STATS ? v : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.S = 1'b0;
    tick();
    tick();
    check("rst_yq",      bus.Y_q, 64'd0);
    check("rst_cnt",     bus.switch_cnt, 64'd0);
    check("rst_cnt_sat", cnt_sat, 64'd0);

    rst   = 1'b0;
    bus.A = 32'hAAAA_AAAA;
    bus.B = 32'h5555_5555;
    bus.S = 1'b0;
    #1;
    check("y_s0_a", bus.Y, 64'hAAAA_AAAA);
    tick();
    check("yq_s0_a",      bus.Y_q, 64'hAAAA_AAAA);
    check("cnt_first_cy", bus.switch_cnt, 64'd0);

    bus.S = 1'b1;
    #1;
    check("y_s1_comb",   bus.Y, 64'h5555_5555);
    check("yq_not_yet",  bus.Y_q, 64'hAAAA_AAAA);
    tick();
    check("yq_s1_b",     bus.Y_q, 64'h5555_5555);
    check("cnt_1",       bus.switch_cnt, exp_cnt(1));

    bus.A = 32'h1234_5678;
    bus.B = 32'h8765_4321;
    bus.S = 1'b0;
    #1;
    check("y_1234",  bus.Y, 64'h1234_5678);
    tick();
    check("yq_1234", bus.Y_q, 64'h1234_5678);
    check("cnt_2",   bus.switch_cnt, exp_cnt(2));
    bus.S = 1'b1;
    #1;
    check("y_8765",  bus.Y, 64'h8765_4321);
    tick();
    check("yq_8765", bus.Y_q, 64'h8765_4321);
    check("cnt_3",   bus.switch_cnt, exp_cnt(3));
    check("sat_at_3", cnt_sat, exp_cnt(3));

    bus.S = 1'b0;
    tick();
    check("cnt_4",     bus.switch_cnt, exp_cnt(4));
    check("sat_holds", cnt_sat, exp_cnt(3));

    rst   = 1'b1;
    bus.S = 1'b1;
    #1;
    check("y_in_rst_pre", bus.Y, 64'h8765_4321);
    tick();
    check("midrst_cnt",     bus.switch_cnt, 64'd0);
    check("midrst_yq",      bus.Y_q, 64'd0);
    check("midrst_cnt_sat", cnt_sat, 64'd0);
    check("midrst_y",       bus.Y, 64'h8765_4321);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_nocnt", bus.switch_cnt, 64'd0);
    check("post_rst_yq",    bus.Y_q, 64'h8765_4321);

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) bus.S = ~bus.S;
      tick();
    end
    check("cnt_5",     bus.switch_cnt, exp_cnt(5));
    check("sat_5",     cnt_sat, exp_cnt(3));
    check("yq_after5", bus.Y_q, 64'h1234_5678);
    check("sat_yq",    yq_sat, 64'h1234_5678);

    bus.A = 32'hDEAD_BEEF;
    bus.B = 32'h0F0F_0F0F;
    bus.S = 1'b1;
    #1;
    check("y_all_chg",  bus.Y, 64'h0F0F_0F0F);
    check("yq_all_old", bus.Y_q, 64'h1234_5678);
    tick();
    check("yq_all_chg", bus.Y_q, 64'h0F0F_0F0F);
    check("cnt_6",      bus.switch_cnt, exp_cnt(6));
    check("sat_y",      y_sat, 64'h0F0F_0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
